// File: rtl/single_port_ram.sv
// Synchronous single-port RAM with write-first registered read.
// Define SINGLE_PORT_RAM_OUTREG_EN to add a second output register (2-cycle read latency).
module single_port_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Array starts zeroed and is never cleared by rst.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (we) begin
      mem[addr] <= din;
      rd_q      <= din;
    end else begin
      rd_q <= mem[addr];
    end
  end

`ifdef SINGLE_PORT_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign dout = out_q;
`else
  assign dout = rd_q;
`endif

endmodule

// File: tb/tb_single_port_ram.sv
// Directed self-checking bench for single_port_ram (both output-register builds).
module tb_single_port_ram;

`ifdef SINGLE_PORT_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din  = '0;
  logic [7:0] dout;

  int n_run  = 0;
  int n_fail = 0;

  single_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .dout (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r; we = w; addr = a; din = d;
    @(posedge clk);
    #1;
  endtask

  // Idle read cycles so the last access reaches dout.
  task automatic wait_lat();
    repeat (LAT - 1) begin
      @(negedge clk);
      rst = 1'b0; we = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    access(1'b1, 1'b0, 4'h0, 8'h00);
    check("reset_dout", dout, 8'h00);

    // 1: preload, then reset with write attempted
    access(1'b0, 1'b1, 4'h3, 8'h77);
    wait_lat();
    check("preload_wf", dout, 8'h77);
    access(1'b1, 1'b1, 4'h3, 8'hFF);
    check("rst_edge1", dout, 8'h00);
    access(1'b1, 1'b1, 4'h3, 8'hFF);
    check("rst_edge2", dout, 8'h00);
    access(1'b0, 1'b0, 4'h3, 8'h00);
    wait_lat();
    check("rst_kept_mem3", dout, 8'h77);

    // 6: untouched word reads zero
    access(1'b0, 1'b0, 4'h9, 8'h00);
    wait_lat();
    check("init_mem9", dout, 8'h00);

    // 2: write-first then steady re-read
    access(1'b0, 1'b1, 4'h1, 8'hA5);
    wait_lat();
    check("wr_first_a5", dout, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b0, 4'h1, 8'h00);
      check("hold_a5", dout, 8'hA5);
    end

    // 3: boundary addresses
    access(1'b0, 1'b1, 4'h0, 8'h3C);
    access(1'b0, 1'b1, 4'hF, 8'hC3);
    access(1'b0, 1'b0, 4'h0, 8'h00);
    wait_lat();
    check("rd_addr0", dout, 8'h3C);
    access(1'b0, 1'b0, 4'hF, 8'h00);
    wait_lat();
    check("rd_addrF", dout, 8'hC3);
    access(1'b0, 1'b0, 4'h1, 8'h00);
    wait_lat();
    check("rd_addr1_kept", dout, 8'hA5);

    // 4: back-to-back overwrite; with two stages the prior A5 read is still in flight
    access(1'b0, 1'b1, 4'h5, 8'h11);
    check("ovw_first", dout, (LAT == 1) ? 8'h11 : 8'hA5);
    access(1'b0, 1'b1, 4'h5, 8'h22);
    check("ovw_second", dout, (LAT == 1) ? 8'h22 : 8'h11);
    wait_lat();
    check("ovw_settled", dout, 8'h22);
    access(1'b0, 1'b0, 4'h5, 8'h00);
    wait_lat();
    check("ovw_readback", dout, 8'h22);

    // 5: sweep write then pipelined read, one result per cycle
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b1, 4'(i), 8'(i) ^ 8'h5A);
    end
    for (int i = 0; i < 16 + LAT - 1; i++) begin
      access(1'b0, 1'b0, 4'(i < 16 ? i : 15), 8'h00);
      if (i >= LAT - 1) begin
        check("sweep_rd", dout, 8'(i - LAT + 1) ^ 8'h5A);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
